// File: rtl/servo_pkg.sv
// Shared types and constants for the servo frame sequencer.
package servo_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] ERR_SYNC  = 2'b01;
  localparam logic [1:0] ERR_CKSUM = 2'b10;
  localparam logic [1:0] ERR_SHORT = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

endpackage

// File: rtl/servo_frame_timer.sv
// Inter-byte timeout counter: counts while enabled, cleared on demand,
// and stops at TIMEOUT_CYC with o_expired held high.
module servo_frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired = (r_cnt == TW'(TIMEOUT_CYC));
  assign o_expired = w_expired;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_expired) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/servo_frame_ctrl.sv
// Frame sequencer between the SPI byte receiver and the servo position shift register.
// Define SERVO_FRAME_CKSUM_EN to require a trailing checksum byte on every frame.
//
// state | meaning
// IDLE  | waiting for the sync byte inside a cs window
// DATA  | shifting position bytes out, summing them
// CHECK | waiting for the checksum byte (checksum builds only)
// DONE  | frame committed, bytes ignored until cs drops
// DRAIN | frame rejected, bytes ignored until cs drops
module servo_frame_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DFLT,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs_active,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_shift,
  output logic [7:0] o_shift_data,
  output logic       o_commit,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_err_count
);

  localparam int unsigned CW = $clog2(N_CH + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_shift;
  logic            w_shift_nxt;
  logic [7:0]      r_shift_data;
  logic [7:0]      w_data_nxt;
  logic            r_commit;
  logic            w_commit_nxt;
  logic            r_frame_err;
  logic            w_err_nxt;
  logic [1:0]      r_err_code;
  logic [1:0]      w_code_nxt;
  logic [7:0]      r_err_count;
  logic            r_busy;
  logic            w_accept;
  logic            w_tmr_en;
  logic            w_tmr_clr;
  logic            w_expired;
`ifdef SERVO_FRAME_CKSUM_EN
  logic [7:0]      r_sum;
  logic [7:0]      w_sum_nxt;
`else
  logic            r_commit_arm;
`endif

  assign w_tmr_en  = (r_state == DATA) || (r_state == CHECK);
  assign w_tmr_clr = w_accept || !w_tmr_en;

  servo_frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  // Priority inside a frame: cs loss, then a received byte, then timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = 1'b0;
    w_data_nxt   = r_shift_data;
    w_commit_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_code_nxt   = 2'b00;
    w_accept     = 1'b0;
`ifdef SERVO_FRAME_CKSUM_EN
    w_sum_nxt    = r_sum;
`endif
    case (r_state)
      IDLE: begin
        if (i_rx_valid && i_cs_active) begin
          w_accept = 1'b1;
          if (i_rx_data == SYNC_BYTE) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = '0;
`ifdef SERVO_FRAME_CKSUM_EN
            w_sum_nxt   = 8'h00;
`endif
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_SYNC;
            w_state_nxt = DRAIN;
          end
        end
      end
      DATA: begin
        if (!i_cs_active) begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = ERR_SHORT;
          w_state_nxt = IDLE;
        end else if (i_rx_valid) begin
          w_accept    = 1'b1;
          w_shift_nxt = 1'b1;
          w_data_nxt  = i_rx_data;
          w_cnt_nxt   = r_cnt + CW'(1);
`ifdef SERVO_FRAME_CKSUM_EN
          w_sum_nxt   = r_sum + i_rx_data;
          if (r_cnt == CW'(N_CH - 1)) w_state_nxt = CHECK;
`else
          // Arms the commit stage so it lands one cycle after the last shift.
          if (r_cnt == CW'(N_CH - 1)) begin
            w_state_nxt  = DONE;
            w_commit_nxt = 1'b1;
          end
`endif
        end else if (w_expired) begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = ERR_SHORT;
          w_state_nxt = DRAIN;
        end
      end
`ifdef SERVO_FRAME_CKSUM_EN
      CHECK: begin
        if (!i_cs_active) begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = ERR_SHORT;
          w_state_nxt = IDLE;
        end else if (i_rx_valid) begin
          w_accept = 1'b1;
          if (i_rx_data == r_sum) begin
            w_commit_nxt = 1'b1;
            w_state_nxt  = DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_CKSUM;
            w_state_nxt = DRAIN;
          end
        end else if (w_expired) begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = ERR_SHORT;
          w_state_nxt = DRAIN;
        end
      end
`endif
      DONE, DRAIN: begin
        if (!i_cs_active) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= 1'b0;
      r_shift_data <= 8'h00;
      r_commit     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'b00;
      r_err_count  <= 8'h00;
      r_busy       <= 1'b0;
`ifdef SERVO_FRAME_CKSUM_EN
      r_sum        <= 8'h00;
`else
      r_commit_arm <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_shift_data <= w_data_nxt;
      r_frame_err  <= w_err_nxt;
      r_err_code   <= w_code_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      if (w_err_nxt && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
`ifdef SERVO_FRAME_CKSUM_EN
      r_sum        <= w_sum_nxt;
      r_commit     <= w_commit_nxt;
`else
      r_commit_arm <= w_commit_nxt;
      r_commit     <= r_commit_arm;
`endif
    end
  end

  assign o_shift      = r_shift;
  assign o_shift_data = r_shift_data;
  assign o_commit     = r_commit;
  assign o_busy       = r_busy;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_servo_frame_ctrl.sv
// Directed scoreboard bench for servo_frame_ctrl; follows SERVO_FRAME_CKSUM_EN when defined.
module tb_servo_frame_ctrl;

  localparam int unsigned N_CH = 8;
  localparam int unsigned TO   = 20;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       rxv;
  logic [7:0] rxd;
  logic       o_shift;
  logic [7:0] o_shift_data;
  logic       o_commit;
  logic       o_busy;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic [7:0] o_err_count;

  int n_chk = 0;
  int n_err = 0;
  int exp_errs = 0;

  logic [7:0] q_shift[$];
  logic [1:0] q_err[$];
  int         q_commit[$];

  servo_frame_ctrl #(
    .N_CH        (N_CH),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cs_active  (cs),
    .i_rx_valid   (rxv),
    .i_rx_data    (rxd),
    .o_shift      (o_shift),
    .o_shift_data (o_shift_data),
    .o_commit     (o_commit),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_err_code   (o_err_code),
    .o_err_count  (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Scoreboard side: every output event must match the next queued expectation.
  always @(negedge clk) begin
    if (o_shift === 1'b1) begin
      chk("shift_expected", 32'(q_shift.size() != 0), 1);
      if (q_shift.size() != 0) chk("shift_data", o_shift_data, q_shift.pop_front());
    end
    if (o_commit === 1'b1) begin
      chk("commit_expected", 32'(q_commit.size() != 0), 1);
      if (q_commit.size() != 0) void'(q_commit.pop_front());
    end
    if (o_frame_err === 1'b1) begin
      chk("err_expected", 32'(q_err.size() != 0), 1);
      if (q_err.size() != 0) chk("err_code", o_err_code, q_err.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxv = 1'b1;
    rxd = b;
    cyc();
    rxv = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    q_shift.push_back(b);
    send(b);
  endtask

  task automatic expect_err(input logic [1:0] code);
    q_err.push_back(code);
    exp_errs++;
  endtask

  task automatic end_frame();
    cs = 1'b0;
    cyc();
    chk("idle_after_cs_drop", o_busy, 0);
  endtask

  task automatic good_frame(input logic [7:0] base);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    cs  = 1'b1;
    send(8'hA5);
    for (int i = 0; i < int'(N_CH); i++) begin
      b = base + 8'(i);
      sum = sum + b;
      send_data(b);
    end
    chk("last_shift", o_shift, 1);
    chk("commit_not_early", o_commit, 0);
    q_commit.push_back(1);
`ifdef SERVO_FRAME_CKSUM_EN
    send(sum);
`else
    cyc();
`endif
    chk("commit_pulse", o_commit, 1);
    chk("no_err_good", o_frame_err, 0);
    send(8'h33);
    chk("commit_one_cycle", o_commit, 0);
    chk("done_busy", o_busy, 1);
    end_frame();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cs  = 1'b0;
    rxv = 1'b0;
    rxd = 8'h00;
    cyc();
    cyc();
    chk("rst_shift", o_shift, 0);
    chk("rst_shift_data", o_shift_data, 0);
    chk("rst_commit", o_commit, 0);
    chk("rst_frame_err", o_frame_err, 0);
    chk("rst_err_code", o_err_code, 0);
    chk("rst_err_count", o_err_count, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b0;
    cyc();

    good_frame(8'h10);
    chk("err_count_after_good", o_err_count, sat(exp_errs));

    cs = 1'b1;
    expect_err(2'b01);
    send(8'h5A);
    chk("badsync_frame_err", o_frame_err, 1);
    chk("badsync_code", o_err_code, 2'b01);
    chk("badsync_busy", o_busy, 1);
    chk("badsync_err_count", o_err_count, sat(exp_errs));
    send(8'hA5);
    send(8'h10);
    chk("drain_busy", o_busy, 1);
    end_frame();
    good_frame(8'h40);

`ifdef SERVO_FRAME_CKSUM_EN
    cs = 1'b1;
    send(8'hA5);
    for (int i = 0; i < int'(N_CH); i++) send_data(8'h10 + 8'(i));
    expect_err(2'b10);
    send(8'h00);
    chk("cksum_frame_err", o_frame_err, 1);
    chk("cksum_code", o_err_code, 2'b10);
    chk("cksum_no_commit", o_commit, 0);
    send(8'h9C);
    end_frame();
    chk("cksum_err_count", o_err_count, sat(exp_errs));
`endif

    cs = 1'b1;
    send(8'hA5);
    send_data(8'h10);
    send_data(8'h11);
    expect_err(2'b11);
    cs = 1'b0;
    cyc();
    chk("short_frame_err", o_frame_err, 1);
    chk("short_code", o_err_code, 2'b11);
    chk("short_idle", o_busy, 0);
    cyc();
    chk("short_err_one_cycle", o_frame_err, 0);

    cs = 1'b1;
    send(8'hA5);
    send_data(8'h20);
    expect_err(2'b11);
    cs  = 1'b0;
    rxv = 1'b1;
    rxd = 8'h21;
    cyc();
    rxv = 1'b0;
    chk("coincident_frame_err", o_frame_err, 1);
    chk("coincident_no_shift", o_shift, 0);
    cyc();
    chk("coincident_shift_after", o_shift, 0);
    chk("short_err_count", o_err_count, sat(exp_errs));

    cs = 1'b1;
    send(8'hA5);
    send_data(8'h10);
    expect_err(2'b11);
    k = 0;
    do begin
      cyc();
      k++;
    end while (o_frame_err !== 1'b1 && k < 60);
    chk("timeout_latency", k, TO + 1);
    chk("timeout_drain_busy", o_busy, 1);
    send(8'h11);
    end_frame();

    for (int f = 0; f < 256; f++) begin
      cs = 1'b1;
      expect_err(2'b01);
      send(8'h00);
      cs = 1'b0;
      cyc();
    end
    chk("err_count_saturated", o_err_count, sat(exp_errs));

    cs = 1'b1;
    send(8'hA5);
    send_data(8'h10);
    send_data(8'h11);
    rst = 1'b1;
    rxv = 1'b1;
    rxd = 8'h12;
    cyc();
    rxv = 1'b0;
    exp_errs = 0;
    chk("midrst_shift", o_shift, 0);
    chk("midrst_shift_data", o_shift_data, 0);
    chk("midrst_commit", o_commit, 0);
    chk("midrst_frame_err", o_frame_err, 0);
    chk("midrst_err_code", o_err_code, 0);
    chk("midrst_err_count", o_err_count, 0);
    chk("midrst_busy", o_busy, 0);
    rst = 1'b0;
    cs  = 1'b0;
    cyc();
    chk("midrst_no_commit", o_commit, 0);
    good_frame(8'h20);
    chk("err_count_after_rst", o_err_count, sat(exp_errs));

    cyc();
    cyc();
    chk("shift_queue_empty", q_shift.size(), 0);
    chk("err_queue_empty", q_err.size(), 0);
    chk("commit_queue_empty", q_commit.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/servo_frame_ctrl.md
Name: servo_frame_ctrl

Overview:
- Frame sequencer between the SPI byte receiver and the 8-bit x 64-deep servo position shift register.
- Validates each chip-select-delimited frame: sync byte, N_CH position bytes, checksum byte.
- Drives the shift register's shift/shift_data inputs for position bytes only.
- On a good frame, emits a one-cycle commit strobe so the PWM channels latch the register taps atomically; bad frames are reported and never committed.

Parameters:
- N_CH, 8, position bytes per frame (1..64).
- SYNC_BYTE, 8'hA5, required first byte of every frame.
- TIMEOUT_CYC, 50000, maximum clk cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cs_active  in  1  high while the SPI master holds chip select.
- rx_valid  in  1  one-cycle pulse, rx_data holds a received byte.
- rx_data  in  8  received byte.
- shift  out  1  shift enable to the position shift register.
- shift_data  out  8  byte to shift in.
- commit  out  1  one-cycle pulse: taps hold a validated frame.
- busy  out  1  high while not in IDLE.
- frame_err  out  1  one-cycle pulse on frame rejection.
- err_code  out  2  valid with frame_err: 01 bad sync, 10 checksum mismatch, 11 short frame or timeout.
- err_count  out  8  rejected frames since reset, saturates at 255.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; shift, commit, frame_err, busy = 0; shift_data=0; err_code=0; err_count=0; byte counter, checksum and timer = 0.
  - Shift register contents are not touched.
  - Reset mid-frame abandons the frame with no commit and no error.
- States: IDLE, DATA, CHECK, DONE, DRAIN.
- IDLE:
  - rx_valid with cs_active: byte==SYNC_BYTE -> DATA (count=0, sum=0); otherwise frame_err/01 -> DRAIN.
  - rx_valid without cs_active: ignored.
- DATA:
  - Each rx_valid: shift=1 and shift_data=rx_data on the next cycle (registered, latency 1).
  - sum += byte, mod 256; count++.
  - When count reaches N_CH -> CHECK.
- CHECK:
  - rx_valid: byte==sum -> commit pulse on the next cycle, state DONE; else frame_err/10 -> DRAIN.
  - The commit cycle is always at least one cycle after the final shift pulse.
- DONE: further bytes are ignored. cs_active low -> IDLE.
- DRAIN: all bytes are ignored. cs_active low -> IDLE.
- cs_active falling while in DATA or CHECK: frame_err/11 -> IDLE. A byte arriving in that same cycle is discarded; cs loss takes precedence.
- Timeout:
  - Timer is cleared on each accepted byte and counts in DATA/CHECK.
  - Reaching TIMEOUT_CYC -> frame_err/11 -> DRAIN.
- err_count increments in the same cycle frame_err is registered; it holds at 255.
- busy = (state != IDLE), registered.
- Counters:
  - Byte counter width is clog2(N_CH+1).
  - Timer width is clog2(TIMEOUT_CYC+1).
  - No wrap is possible inside a valid frame.
- Back-to-back frames need cs_active low for at least one cycle between them.

Optional Feature:
- Macro: SERVO_FRAME_CKSUM_EN.
- Defined:
  - CHECK state and checksum byte exist as described.
  - err_code 10 is possible.
- Undefined:
  - No checksum byte; after the N_CH-th position byte the controller goes straight to DONE.
  - commit pulses two cycles after that byte's rx_valid, i.e. one cycle after its shift pulse.
  - Checksum adder is removed; err_code 10 never occurs.

Decomposition:
- Package servo_pkg holds:
  - state enum (IDLE, DATA, CHECK, DONE, DRAIN);
  - err_code constants ERR_SYNC=2'b01, ERR_CKSUM=2'b10, ERR_SHORT=2'b11;
  - default SYNC_BYTE.
- One sub-module is natural: servo_frame_timer, the inter-byte timeout counter with clear/enable inputs and an expired output.
- Checksum and state logic stay in the top module.

Test Plan:
- Good frame, checksum on: N_CH=8, bytes A5,10..17,9C in one cs window -> eight shift pulses carrying 10..17; one commit; no frame_err; err_count=0; busy low after cs drops.
- Bad sync: first byte 5A -> frame_err with err_code=01; no shift; err_count=1; later bytes ignored until cs drops; the next good frame commits.
- Bad checksum: A5,10..17,00 -> eight shifts, frame_err/10, no commit; extra bytes ignored.
- Short frame: A5,10,11 then cs drop -> frame_err/11 in the drop cycle; no commit; IDLE next cycle. Also cs drop coincident with an rx_valid -> that byte produces no shift.
- Timeout: TIMEOUT_CYC=20, A5,10 then 20 idle cycles with cs held -> frame_err/11, DRAIN, returns to IDLE on cs drop. Also 256 bad frames -> err_count stays 255.
- rst asserted mid-DATA -> next cycle all outputs 0, IDLE, err_count=0; with SERVO_FRAME_CKSUM_EN undefined, A5,10..17 -> commit two cycles after byte 17.
